// File: rtl/esc_pwm_generator_if.sv
// Mixer-side rate bundle in, ESC PWM lines and status out.
// master = mixer/testbench side, slave = the PWM generator.
interface esc_pwm_generator_if #(
  parameter int MOTOR_RATE_BIT_WIDTH = 8
);
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate;
  logic                            update_strobe;
  logic                            arm;
  logic                            pwm_1;
  logic                            pwm_2;
  logic                            pwm_3;
  logic                            pwm_4;
  logic                            frame_start;
  logic                            armed;
  logic                            failsafe;

  modport master (
    output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    output update_strobe, arm,
    input  pwm_1, pwm_2, pwm_3, pwm_4, frame_start, armed, failsafe
  );

  modport slave (
    input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    input  update_strobe, arm,
    output pwm_1, pwm_2, pwm_3, pwm_4, frame_start, armed, failsafe
  );
endinterface

// File: rtl/esc_pwm_generator.sv
// Four-channel ESC servo PWM generator: shared frame counter, per-channel
// width latched at frame boundaries, arm/failsafe state machine.

module esc_pwm_lane #(
  parameter int MIN_PULSE_TICKS = 38000,
  parameter int MAX_PULSE_TICKS = 76000,
  parameter int TICKS_PER_STEP  = 149,
  parameter int CNT_WIDTH       = 17,
  parameter int RATE_W          = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 latch,
  input  logic                 pass,
  input  logic [CNT_WIDTH-1:0] cnt_nxt,
  input  logic [RATE_W-1:0]    rate,
  output logic                 pwm
);
  // Wide enough that rate*step+min can never wrap before the clamp.
  localparam int PW = RATE_W + 33;

  logic [PW-1:0]        cmd;
  logic [CNT_WIDTH-1:0] width, width_cmd, width_nxt;

  always_comb begin
    cmd       = PW'(rate) * PW'(TICKS_PER_STEP) + PW'(MIN_PULSE_TICKS);
    width_cmd = (cmd > PW'(MAX_PULSE_TICKS)) ? CNT_WIDTH'(MAX_PULSE_TICKS)
                                             : cmd[CNT_WIDTH-1:0];
    width_nxt = width;
    if (latch) width_nxt = pass ? width_cmd : CNT_WIDTH'(MIN_PULSE_TICKS);
  end

  // pwm is registered against next-cycle count/width so it rises with frame_start.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      width <= CNT_WIDTH'(MIN_PULSE_TICKS);
      pwm   <= 1'b0;
    end else begin
      width <= width_nxt;
      pwm   <= (cnt_nxt < width_nxt);
    end
  end
endmodule

module esc_pwm_generator #(
  parameter int FRAME_TICKS          = 95000,
  parameter int MIN_PULSE_TICKS      = 38000,
  parameter int MAX_PULSE_TICKS      = 76000,
  parameter int TICKS_PER_STEP       = 149,
  parameter int TIMEOUT_FRAMES       = 4,
  parameter int CNT_WIDTH            = 17,
  parameter int MOTOR_RATE_BIT_WIDTH = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  esc_pwm_generator_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int TO_W      = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_FAILSAFE = 2'd2;

  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 latch;
  logic [TO_W-1:0]      to_cnt, to_nxt;
  logic [1:0]           state, state_nxt;
  logic                 pass;
  logic                 frame_start, armed, failsafe;

  logic [NUM_LANES-1:0][MOTOR_RATE_BIT_WIDTH-1:0] rates;
  logic [NUM_LANES-1:0]                           pwm;

  assign rates = {bus.motor_4_rate, bus.motor_3_rate, bus.motor_2_rate, bus.motor_1_rate};

  assign latch   = (cnt == CNT_WIDTH'(FRAME_TICKS - 1));
  assign cnt_nxt = latch ? '0 : cnt + CNT_WIDTH'(1);

  // Strobe clears even in the latch cycle; otherwise count latches, saturating.
  always_comb begin
    to_nxt = to_cnt;
    if (bus.update_strobe)
      to_nxt = '0;
    else if (latch && (to_cnt != TO_W'(TIMEOUT_FRAMES)))
      to_nxt = to_cnt + TO_W'(1);
  end

  // Transitions judge the post-latch timeout count, so the N-th silent latch trips failsafe.
  always_comb begin
    state_nxt = state;
    if (latch) begin
      case (state)
        ST_DISARMED: if (bus.arm && (to_nxt < TO_W'(TIMEOUT_FRAMES))) state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (!bus.arm)                              state_nxt = ST_DISARMED;
          else if (to_nxt == TO_W'(TIMEOUT_FRAMES))  state_nxt = ST_FAILSAFE;
        end
        ST_FAILSAFE: begin
          if (!bus.arm)                              state_nxt = ST_DISARMED;
          else if (to_nxt < TO_W'(TIMEOUT_FRAMES))   state_nxt = ST_ARMED;
        end
        default: state_nxt = ST_DISARMED;
      endcase
    end
  end

  assign pass = (state_nxt == ST_ARMED);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= CNT_WIDTH'(FRAME_TICKS - 1);
      to_cnt      <= '0;
      state       <= ST_DISARMED;
      frame_start <= 1'b0;
      armed       <= 1'b0;
      failsafe    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      to_cnt      <= to_nxt;
      state       <= state_nxt;
      frame_start <= latch;
      armed       <= (state_nxt == ST_ARMED);
      failsafe    <= (state_nxt == ST_FAILSAFE);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    esc_pwm_lane #(
      .MIN_PULSE_TICKS (MIN_PULSE_TICKS),
      .MAX_PULSE_TICKS (MAX_PULSE_TICKS),
      .TICKS_PER_STEP  (TICKS_PER_STEP),
      .CNT_WIDTH       (CNT_WIDTH),
      .RATE_W          (MOTOR_RATE_BIT_WIDTH)
    ) u_lane (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .latch   (latch),
      .pass    (pass),
      .cnt_nxt (cnt_nxt),
      .rate    (rates[i]),
      .pwm     (pwm[i])
    );
  end

  assign bus.pwm_1       = pwm[0];
  assign bus.pwm_2       = pwm[1];
  assign bus.pwm_3       = pwm[2];
  assign bus.pwm_4       = pwm[3];
  assign bus.frame_start = frame_start;
  assign bus.armed       = armed;
  assign bus.failsafe    = failsafe;
endmodule
